// File: rtl/checkpoint_table_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : checkpoint_table_pkg                                      |
// | Purpose  : Default core dimensions, snapshot types and the branch    |
// |            checkpoint entry layout shared by the checkpoint store.   |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package checkpoint_table_pkg;

  // Core-wide default dimensions.
  localparam int N_CKPT_DEF      = 4;
  localparam int N_ARCH_REGS_DEF = 32;
  localparam int N_PHYS_REGS_DEF = 64;
  localparam int PREG_W_DEF      = 6;
  localparam int ROB_W_DEF       = 4;

  localparam int CKPT_IDX_W = $clog2(N_CKPT_DEF);

  // Snapshot types at the default core configuration.
  typedef logic [N_ARCH_REGS_DEF*PREG_W_DEF-1:0] rat_snap_t;
  typedef logic [N_PHYS_REGS_DEF-1:0]            freelist_snap_t;
  typedef logic [N_PHYS_REGS_DEF-1:0]            prf_valid_snap_t;
  typedef logic [2*ROB_W_DEF:0]                  rob_ptrs_snap_t;   // {tail, count}
  typedef logic [ROB_W_DEF-1:0]                  rob_tag_t;

  // One checkpoint slot: CAM key plus the post-rename snapshot.
  typedef struct packed {
    rob_tag_t        key;
    rat_snap_t       rat;
    freelist_snap_t  freelist;
    prf_valid_snap_t prf_valid;
    rob_ptrs_snap_t  rob_ptrs;
    rob_tag_t        tag_ctr;
  } ckpt_entry_t;

  // Number of set bits in a slot mask (up to 16 slots).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0000, v[i]};
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/checkpoint_table_age_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ckpt_age_matrix                                           |
// | Purpose  : Relative age of checkpoint slots. older[i][j]=1 means     |
// |            slot i was allocated before slot j (both live).           |
// | Ports    : clk, rst_n      clock / async active-low reset            |
// |            alloc_en/idx   slot being allocated (becomes youngest)    |
// |            valid          slot occupancy at start of cycle           |
// |            inval_mask     slots cleared this cycle                   |
// |            query_idx      slot whose younger set is wanted           |
// |            younger_mask   slots younger than query_idx               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ckpt_age_matrix
  import checkpoint_table_pkg::*;
#(
  parameter int N_CKPT = N_CKPT_DEF,
  parameter int IDX_W  = CKPT_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [IDX_W-1:0]  alloc_idx,
  input  logic [N_CKPT-1:0] valid,
  input  logic [N_CKPT-1:0] inval_mask,
  input  logic [IDX_W-1:0]  query_idx,
  output logic [N_CKPT-1:0] younger_mask
);

  logic [N_CKPT-1:0] r_older [N_CKPT];

  // A cleared slot drops its whole row and column so that stale ordering
  // never leaks into the slot's next occupant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CKPT; i++) begin
        r_older[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CKPT; i++) begin
        for (int j = 0; j < N_CKPT; j++) begin
          if (inval_mask[i] || inval_mask[j]) begin
            r_older[i][j] <= 1'b0;
          end else if (alloc_en && (IDX_W'(j) == alloc_idx)) begin
            r_older[i][j] <= valid[i];
          end else if (alloc_en && (IDX_W'(i) == alloc_idx)) begin
            r_older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  assign younger_mask = r_older[query_idx];

endmodule
`default_nettype wire

// File: rtl/checkpoint_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : checkpoint_table                                          |
// | Purpose  : Multi-slot branch checkpoint store keyed by ROB tag.      |
// |            Snapshots RAT/free list/PRF-valid/ROB state per branch,   |
// |            keeps free list and PRF-valid live, restores one slot on  |
// |            mispredict and squashes all younger slots.                |
// | Ports    : alloc_*      snapshot request and data, alloc_ok grant    |
// |            resolve_*    release slot of a correctly resolved branch  |
// |            mispredict*  restore request                              |
// |            commit_free_*, wb_*   live snapshot updates               |
// |            restore_*    registered restore pulse and data            |
// |            ckpt_full, n_valid    occupancy                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module checkpoint_table
  import checkpoint_table_pkg::*;
#(
  parameter int N_CKPT      = N_CKPT_DEF,
  parameter int N_ARCH_REGS = N_ARCH_REGS_DEF,
  parameter int N_PHYS_REGS = N_PHYS_REGS_DEF,
  parameter int PREG_W      = PREG_W_DEF,
  parameter int ROB_W       = ROB_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_req,
  input  logic [ROB_W-1:0]              alloc_rob_tag,
  input  logic [N_ARCH_REGS*PREG_W-1:0] alloc_rat,
  input  logic [N_PHYS_REGS-1:0]        alloc_freelist,
  input  logic [N_PHYS_REGS-1:0]        alloc_prf_valid,
  input  logic [2*ROB_W:0]              alloc_rob_ptrs,
  input  logic [ROB_W-1:0]              alloc_tag_ctr,
  output logic                          alloc_ok,
  output logic                          ckpt_full,
  input  logic                          resolve_ok,
  input  logic [ROB_W-1:0]              resolve_rob_tag,
  input  logic                          mispredict,
  input  logic [ROB_W-1:0]              mispredict_rob_tag,
  input  logic                          commit_free_valid,
  input  logic [PREG_W-1:0]             commit_free_preg,
  input  logic                          wb_valid,
  input  logic [PREG_W-1:0]             wb_preg,
  output logic                          restore_valid,
  output logic                          restore_miss,
  output logic [N_ARCH_REGS*PREG_W-1:0] restore_rat,
  output logic [N_PHYS_REGS-1:0]        restore_freelist,
  output logic [N_PHYS_REGS-1:0]        restore_prf_valid,
  output logic [2*ROB_W:0]              restore_rob_ptrs,
  output logic [ROB_W-1:0]              restore_tag_ctr,
  output logic [$clog2(N_CKPT+1)-1:0]   n_valid
);

  localparam int IDX_W = $clog2(N_CKPT);
  localparam int NV_W  = $clog2(N_CKPT+1);
  localparam logic [N_PHYS_REGS-1:0] c_phys_one = {{(N_PHYS_REGS-1){1'b0}}, 1'b1};
  localparam logic [N_CKPT-1:0]      c_slot_one = {{(N_CKPT-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [ROB_W-1:0]              key;
    logic [N_ARCH_REGS*PREG_W-1:0] rat;
    logic [N_PHYS_REGS-1:0]        freelist;
    logic [N_PHYS_REGS-1:0]        prf_valid;
    logic [2*ROB_W:0]              rob_ptrs;
    logic [ROB_W-1:0]              tag_ctr;
  } slot_t;

  logic [N_CKPT-1:0] r_valid;
  slot_t             r_slot [N_CKPT];
  logic [NV_W-1:0]   r_n_valid;

  logic [IDX_W-1:0]       w_free_idx;
  logic [IDX_W-1:0]       w_mis_idx;
  logic [N_CKPT-1:0]      w_mis_hit_vec;
  logic [N_CKPT-1:0]      w_res_hit_vec;
  logic [N_CKPT-1:0]      w_younger;
  logic [N_CKPT-1:0]      w_squash;
  logic [N_CKPT-1:0]      w_clear;
  logic [N_CKPT-1:0]      w_alloc_oh;
  logic                   w_mis_hit;
  logic [N_PHYS_REGS-1:0] w_free_set;
  logic [N_PHYS_REGS-1:0] w_wb_set;

  assign n_valid   = r_n_valid;
  assign ckpt_full = (r_n_valid == NV_W'(N_CKPT));
  // Gated by rst_n so the grant reads 0 while reset is held.
  assign alloc_ok  = rst_n & alloc_req & ~ckpt_full & ~mispredict;

  // Lowest-index slot free at the start of the cycle; slots released this
  // cycle only become visible here on the next cycle.
  always_comb begin
    w_free_idx = '0;
    for (int i = N_CKPT-1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  // Tag CAM for mispredict and resolve. Tags are unique among live slots.
  always_comb begin
    w_mis_hit_vec = '0;
    w_res_hit_vec = '0;
    w_mis_idx     = '0;
    for (int i = 0; i < N_CKPT; i++) begin
      w_mis_hit_vec[i] = r_valid[i] && (r_slot[i].key == mispredict_rob_tag);
      w_res_hit_vec[i] = resolve_ok && r_valid[i] && (r_slot[i].key == resolve_rob_tag);
      if (w_mis_hit_vec[i]) w_mis_idx = IDX_W'(i);
    end
  end

  assign w_mis_hit  = mispredict & (|w_mis_hit_vec);
  assign w_squash   = w_mis_hit ? (w_mis_hit_vec | (w_younger & r_valid)) : '0;
  // Resolve and squash may name the same slot; OR-ing makes that harmless.
  assign w_clear    = w_squash | w_res_hit_vec;
  assign w_alloc_oh = alloc_ok ? (c_slot_one << w_free_idx) : '0;
  assign w_free_set = commit_free_valid ? (c_phys_one << commit_free_preg) : '0;
  assign w_wb_set   = wb_valid ? (c_phys_one << wb_preg) : '0;

  ckpt_age_matrix #(
    .N_CKPT (N_CKPT),
    .IDX_W  (IDX_W)
  ) u_age (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en     (alloc_ok),
    .alloc_idx    (w_free_idx),
    .valid        (r_valid),
    .inval_mask   (w_clear),
    .query_idx    (w_mis_idx),
    .younger_mask (w_younger)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_n_valid <= '0;
    end else begin
      r_valid   <= (r_valid & ~w_clear) | w_alloc_oh;
      r_n_valid <= r_n_valid + NV_W'(alloc_ok) - NV_W'(popcount16(16'(w_clear)));
    end
  end

  // Snapshot payload; free-list and ready bits track commit/writeback
  // every cycle so a later restore sees the current picture.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CKPT; i++) begin
      if (w_alloc_oh[i]) begin
        r_slot[i].key       <= alloc_rob_tag;
        r_slot[i].rat       <= alloc_rat;
        r_slot[i].freelist  <= alloc_freelist | w_free_set;
        r_slot[i].prf_valid <= alloc_prf_valid | w_wb_set;
        r_slot[i].rob_ptrs  <= alloc_rob_ptrs;
        r_slot[i].tag_ctr   <= alloc_tag_ctr;
      end else begin
        r_slot[i].freelist  <= r_slot[i].freelist | w_free_set;
        r_slot[i].prf_valid <= r_slot[i].prf_valid | w_wb_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restore_valid     <= 1'b0;
      restore_miss      <= 1'b0;
      restore_rat       <= '0;
      restore_freelist  <= '0;
      restore_prf_valid <= '0;
      restore_rob_ptrs  <= '0;
      restore_tag_ctr   <= '0;
    end else begin
      restore_valid <= w_mis_hit;
      restore_miss  <= mispredict & ~w_mis_hit;
      if (w_mis_hit) begin
        restore_rat       <= r_slot[w_mis_idx].rat;
        restore_freelist  <= r_slot[w_mis_idx].freelist | w_free_set;
        restore_prf_valid <= r_slot[w_mis_idx].prf_valid | w_wb_set;
        restore_rob_ptrs  <= r_slot[w_mis_idx].rob_ptrs;
        restore_tag_ctr   <= r_slot[w_mis_idx].tag_ctr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_checkpoint_table                                       |
// | Purpose  : Self-checking bench for checkpoint_table: directed vector |
// |            table, snapshot-update sequences, random traffic against  |
// |            a slot-list reference model, and asynchronous reset.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_checkpoint_table;

  localparam int N     = 4;
  localparam int RAT_W = 192;
  localparam int PW    = 64;
  localparam int PTR_W = 9;
  localparam int TW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_req;
  logic [TW-1:0]    alloc_rob_tag;
  logic [RAT_W-1:0] alloc_rat;
  logic [PW-1:0]    alloc_freelist;
  logic [PW-1:0]    alloc_prf_valid;
  logic [PTR_W-1:0] alloc_rob_ptrs;
  logic [TW-1:0]    alloc_tag_ctr;
  logic             alloc_ok;
  logic             ckpt_full;
  logic             resolve_ok;
  logic [TW-1:0]    resolve_rob_tag;
  logic             mispredict;
  logic [TW-1:0]    mispredict_rob_tag;
  logic             commit_free_valid;
  logic [5:0]       commit_free_preg;
  logic             wb_valid;
  logic [5:0]       wb_preg;
  logic             restore_valid;
  logic             restore_miss;
  logic [RAT_W-1:0] restore_rat;
  logic [PW-1:0]    restore_freelist;
  logic [PW-1:0]    restore_prf_valid;
  logic [PTR_W-1:0] restore_rob_ptrs;
  logic [TW-1:0]    restore_tag_ctr;
  logic [2:0]       n_valid;

  checkpoint_table dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_rob_tag(alloc_rob_tag), .alloc_rat(alloc_rat),
    .alloc_freelist(alloc_freelist), .alloc_prf_valid(alloc_prf_valid),
    .alloc_rob_ptrs(alloc_rob_ptrs), .alloc_tag_ctr(alloc_tag_ctr),
    .alloc_ok(alloc_ok), .ckpt_full(ckpt_full),
    .resolve_ok(resolve_ok), .resolve_rob_tag(resolve_rob_tag),
    .mispredict(mispredict), .mispredict_rob_tag(mispredict_rob_tag),
    .commit_free_valid(commit_free_valid), .commit_free_preg(commit_free_preg),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .restore_valid(restore_valid), .restore_miss(restore_miss),
    .restore_rat(restore_rat), .restore_freelist(restore_freelist),
    .restore_prf_valid(restore_prf_valid), .restore_rob_ptrs(restore_rob_ptrs),
    .restore_tag_ctr(restore_tag_ctr), .n_valid(n_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a set of live checkpoints, age given by allocation order.
  bit               m_v    [N];
  bit [TW-1:0]      m_tag  [N];
  int               m_seq  [N];
  bit [RAT_W-1:0]   m_rat  [N];
  bit [PW-1:0]      m_fl   [N];
  bit [PW-1:0]      m_prf  [N];
  bit [PTR_W-1:0]   m_ptr  [N];
  bit [TW-1:0]      m_ctr  [N];
  int               m_next_seq;
  bit               e_rv, e_rm;
  bit [RAT_W-1:0]   e_rat;
  bit [PW-1:0]      e_fl, e_prf;
  bit [PTR_W-1:0]   e_ptr;
  bit [TW-1:0]      e_ctr;

  typedef struct {
    bit      areq;
    bit [3:0] atag;
    bit      rok;
    bit [3:0] rtag;
    bit      mis;
    bit [3:0] mtag;
    bit      e_aok;
    int      e_nv;
    bit      e_rv;
    bit      e_rm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) c++;
    return c;
  endfunction

  function automatic bit m_has_tag(input bit [TW-1:0] t);
    for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_next_seq = 0;
    e_rv = 0; e_rm = 0; e_rat = '0; e_fl = '0; e_prf = '0; e_ptr = '0; e_ctr = '0;
  endtask

  // One clock edge of the reference model, using the inputs currently driven.
  task automatic m_update();
    int         k, fs, ks;
    bit         aok;
    bit [PW-1:0] fset, wset;
    aok  = alloc_req && (m_count() < N) && !mispredict;
    fset = commit_free_valid ? (64'd1 << commit_free_preg) : 64'd0;
    wset = wb_valid ? (64'd1 << wb_preg) : 64'd0;
    fs = -1;
    for (int i = 0; i < N; i++) if (!m_v[i] && fs < 0) fs = i;
    k = -1;
    for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == mispredict_rob_tag) k = i;
    for (int i = 0; i < N; i++) begin
      m_fl[i]  = m_fl[i] | fset;
      m_prf[i] = m_prf[i] | wset;
    end
    e_rv = 0; e_rm = 0;
    if (mispredict) begin
      if (k >= 0) begin
        e_rv = 1; e_rat = m_rat[k]; e_fl = m_fl[k]; e_prf = m_prf[k];
        e_ptr = m_ptr[k]; e_ctr = m_ctr[k];
        ks = m_seq[k];
        for (int i = 0; i < N; i++) if (m_v[i] && m_seq[i] >= ks) m_v[i] = 0;
      end else begin
        e_rm = 1;
      end
    end
    if (resolve_ok)
      for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == resolve_rob_tag) m_v[i] = 0;
    if (aok) begin
      m_v[fs] = 1; m_tag[fs] = alloc_rob_tag; m_seq[fs] = m_next_seq++;
      m_rat[fs] = alloc_rat; m_fl[fs] = alloc_freelist | fset;
      m_prf[fs] = alloc_prf_valid | wset; m_ptr[fs] = alloc_rob_ptrs; m_ctr[fs] = alloc_tag_ctr;
    end
  endtask

  task automatic idle();
    alloc_req = 0; alloc_rob_tag = '0; resolve_ok = 0; resolve_rob_tag = '0;
    mispredict = 0; mispredict_rob_tag = '0;
    commit_free_valid = 0; commit_free_preg = '0; wb_valid = 0; wb_preg = '0;
  endtask

  task automatic rand_payload();
    for (int b = 0; b < RAT_W/32; b++) alloc_rat[b*32 +: 32] = $urandom();
    alloc_freelist  = {$urandom(), $urandom()};
    alloc_prf_valid = {$urandom(), $urandom()};
    alloc_rob_ptrs  = PTR_W'($urandom());
    alloc_tag_ctr   = TW'($urandom());
  endtask

  // Called at the falling edge with inputs driven.
  task automatic pre_edge();
    #1;
    chk("alloc_ok", alloc_ok, alloc_req && (m_count() < N) && !mispredict);
    chk("ckpt_full", ckpt_full, m_count() == N);
  endtask

  task automatic post_edge();
    @(posedge clk);
    m_update();
    #1;
    chk("n_valid", n_valid, m_count());
    chk("restore_valid", restore_valid, e_rv);
    chk("restore_miss", restore_miss, e_rm);
    chk("restore_rat", restore_rat, e_rat);
    chk("restore_freelist", restore_freelist, e_fl);
    chk("restore_prf_valid", restore_prf_valid, e_prf);
    chk("restore_rob_ptrs", restore_rob_ptrs, e_ptr);
    chk("restore_tag_ctr", restore_tag_ctr, e_ctr);
  endtask

  task automatic step();
    pre_edge();
    post_edge();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_alloc_ok"}, alloc_ok, 0);
    chk({pfx, "_ckpt_full"}, ckpt_full, 0);
    chk({pfx, "_n_valid"}, n_valid, 0);
    chk({pfx, "_restore_valid"}, restore_valid, 0);
    chk({pfx, "_restore_miss"}, restore_miss, 0);
    chk({pfx, "_restore_rat"}, restore_rat, 0);
    chk({pfx, "_restore_freelist"}, restore_freelist, 0);
    chk({pfx, "_restore_prf_valid"}, restore_prf_valid, 0);
    chk({pfx, "_restore_rob_ptrs"}, restore_rob_ptrs, 0);
    chk({pfx, "_restore_tag_ctr"}, restore_tag_ctr, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // {areq, atag, rok, rtag, mis, mtag, exp alloc_ok, exp n_valid, exp rv, exp rm}
    tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 1, 2, 0, 0});
    tbl.push_back('{1, 3, 0, 0, 0, 0, 1, 3, 0, 0});
    tbl.push_back('{1, 4, 0, 0, 0, 0, 1, 4, 0, 0});
    tbl.push_back('{1, 5, 0, 0, 0, 0, 0, 4, 0, 0});   // table full
    tbl.push_back('{0, 0, 1, 2, 0, 0, 0, 3, 0, 0});   // resolve tag 2
    tbl.push_back('{1, 5, 0, 0, 0, 0, 1, 4, 0, 0});   // reuses freed slot
    tbl.push_back('{0, 0, 0, 0, 1, 5, 0, 3, 1, 0});   // tag 5 is youngest
    tbl.push_back('{0, 0, 0, 0, 1, 2, 0, 3, 0, 1});   // tag 2 gone: miss
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 1, 0});   // oldest: squash all
    tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 1, 2, 0, 0});
    tbl.push_back('{1, 3, 0, 0, 0, 0, 1, 3, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 2, 0, 1, 1, 0});   // squash 2 and 3
    tbl.push_back('{0, 0, 0, 0, 1, 6, 0, 1, 0, 1});   // absent tag
    tbl.push_back('{1, 8, 0, 0, 1, 1, 0, 0, 1, 0});   // alloc dropped
    tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 1, 2, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 0, 1, 0});   // resolve+mispredict same tag
    tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 1, 2, 0, 0});
    tbl.push_back('{1, 3, 0, 0, 0, 0, 1, 3, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 3, 0, 1, 1, 0});   // resolve 1, squash 3
    tbl.push_back('{0, 0, 0, 0, 1, 2, 0, 0, 1, 0});

    rst_n = 0;
    idle();
    rand_payload();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;

    foreach (tbl[v]) begin
      idle();
      rand_payload();
      alloc_req = tbl[v].areq; alloc_rob_tag = tbl[v].atag;
      resolve_ok = tbl[v].rok; resolve_rob_tag = tbl[v].rtag;
      mispredict = tbl[v].mis; mispredict_rob_tag = tbl[v].mtag;
      pre_edge();
      chk($sformatf("tbl%0d_alloc_ok", v), alloc_ok, tbl[v].e_aok);
      post_edge();
      chk($sformatf("tbl%0d_n_valid", v), n_valid, tbl[v].e_nv);
      chk($sformatf("tbl%0d_restore_valid", v), restore_valid, tbl[v].e_rv);
      chk($sformatf("tbl%0d_restore_miss", v), restore_miss, tbl[v].e_rm);
      @(negedge clk);
    end

    // Snapshot kept live by later commit frees and writebacks.
    idle(); rand_payload();
    alloc_req = 1; alloc_rob_tag = 7; alloc_freelist = '0; alloc_prf_valid = '0;
    step();
    idle(); commit_free_valid = 1; commit_free_preg = 9; step();
    idle(); wb_valid = 1; wb_preg = 12; step();
    idle(); mispredict = 1; mispredict_rob_tag = 7; step();
    chk("live_freelist", restore_freelist, 64'h0000_0000_0000_0200);
    chk("live_prf_valid", restore_prf_valid, 64'h0000_0000_0000_1000);

    // Same-cycle updates on the allocating and on the restoring edge.
    idle(); rand_payload();
    alloc_req = 1; alloc_rob_tag = 3; alloc_freelist = '0; alloc_prf_valid = '0;
    commit_free_valid = 1; commit_free_preg = 5;
    step();
    idle(); mispredict = 1; mispredict_rob_tag = 3; wb_valid = 1; wb_preg = 20;
    step();
    chk("same_cycle_freelist", restore_freelist, 64'h0000_0000_0000_0020);
    chk("same_cycle_prf_valid", restore_prf_valid, 64'h0000_0000_0010_0000);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      idle(); rand_payload();
      alloc_rob_tag      = TW'($urandom_range(0, 15));
      alloc_req          = ($urandom_range(0, 2) != 0) && !m_has_tag(alloc_rob_tag);
      mispredict         = ($urandom_range(0, 7) == 0);
      mispredict_rob_tag = TW'($urandom_range(0, 15));
      resolve_ok         = ($urandom_range(0, 4) == 0);
      resolve_rob_tag    = m_tag[$urandom_range(0, N-1)];
      commit_free_valid  = $urandom_range(0, 1) == 1;
      commit_free_preg   = 6'($urandom());
      wb_valid           = $urandom_range(0, 1) == 1;
      wb_preg            = 6'($urandom());
      step();
    end

    // Make sure the table holds something, then reset asynchronously.
    idle(); rand_payload();
    alloc_req = (m_count() < N); alloc_rob_tag = 15;
    if (m_has_tag(15)) alloc_req = 0;
    step();
    idle(); mispredict = 1; mispredict_rob_tag = 6;
    if (m_has_tag(6)) mispredict_rob_tag = 15;
    step();
    idle();
    alloc_req = 1;
    #2 rst_n = 0;
    #1;
    chk_all_zero("async_reset");
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int t = 1; t <= 3; t++) begin
      idle(); rand_payload();
      alloc_req = 1; alloc_rob_tag = TW'(t);
      step();
    end
    idle(); mispredict = 1; mispredict_rob_tag = 2;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/checkpoint_table.md
Name: checkpoint_table

Overview:
- Parametrised multi-slot branch checkpoint store for Phase 4 recovery.
- Sits beside rename. On a branch or jump it takes a post-rename snapshot: RAT, free list, PRF-valid, ROB pointers and ROB tag counter.
- Unlike a fixed one-snapshot-per-tag store, it holds N_CKPT slots, keyed by ROB tag through a CAM.
- It tracks slot age and keeps the free-list and PRF-valid snapshots live against commit frees and writebacks.
- On a mispredict it restores one slot and squashes every younger slot.

Parameters:
- N_CKPT, 4, number of checkpoint slots (2..16).
- N_ARCH_REGS, 32, architectural registers.
- N_PHYS_REGS, 64, physical registers.
- PREG_W, 6, physical register index width.
- ROB_W, 4, ROB tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  take a checkpoint this cycle.
- alloc_rob_tag  in  ROB_W  ROB tag of the branch.
- alloc_rat  in  N_ARCH_REGS*PREG_W  RAT after renaming the branch.
- alloc_freelist  in  N_PHYS_REGS  free list after rename (1 = free).
- alloc_prf_valid  in  N_PHYS_REGS  PRF ready bits.
- alloc_rob_ptrs  in  ROB_W+ROB_W+1  {tail, count}.
- alloc_tag_ctr  in  ROB_W  next-tag counter.
- alloc_ok  out  1  combinational; slot was granted.
- ckpt_full  out  1  registered-state derived; no free slot.
- resolve_ok  in  1  branch resolved correct; release its slot.
- resolve_rob_tag  in  ROB_W  tag for resolve_ok.
- mispredict  in  1  branch mispredicted.
- mispredict_rob_tag  in  ROB_W  tag of the mispredicted branch.
- commit_free_valid  in  1  commit returns a preg to the free list.
- commit_free_preg  in  PREG_W  that preg.
- wb_valid  in  1  writeback marks a preg ready.
- wb_preg  in  PREG_W  that preg.
- restore_valid  out  1  registered; restore data valid.
- restore_miss  out  1  registered; mispredict tag not found.
- restore_rat, restore_freelist, restore_prf_valid, restore_rob_ptrs, restore_tag_ctr  out  widths as alloc_*  registered snapshot.
- n_valid  out  $clog2(N_CKPT+1)  occupied slot count.

Behaviour:
- Reset (async, rst_n=0): all slot valid bits 0, age matrix 0, restore_valid=0, restore_miss=0, all restore_* data=0, n_valid=0, ckpt_full=0, alloc_ok=0.
- Per-slot state: valid, rob_tag, snapshot fields. Age matrix: older[i][j]=1 means slot i is older than slot j.
- Allocation: ckpt_full = (n_valid==N_CKPT), computed from state at the start of the cycle.
  - alloc_ok = alloc_req & ~ckpt_full & ~mispredict.
  - On grant, the lowest-index free slot is written at the clock edge and the new slot becomes youngest: older[j][new]=1 for every valid j; older[new][*]=0.
  - A slot freed in the same cycle is not reusable until the next cycle.
- Live update: every cycle, for every valid slot:
  - commit_free_valid sets freelist[commit_free_preg]=1.
  - wb_valid sets prf_valid[wb_preg]=1.
  - A slot allocated in the same cycle stores its alloc_* values OR'ed with these same-cycle updates.
- Resolve: resolve_ok with a matching valid tag clears that slot. No match: no effect.
- Mispredict: CAM match on mispredict_rob_tag among valid slots (one hit at most; tags are unique).
  - Hit slot k: the next cycle gives restore_valid=1 and restore_* = slot k contents, including same-cycle commit/wb updates. Slot k and every slot j with older[k][j]=1 are invalidated at the same edge.
  - Miss: the next cycle gives restore_valid=0, restore_miss=1, and no state change.
  - restore_valid and restore_miss are 1-cycle pulses. restore_* data holds its value until the next hit.
- Simultaneous events:
  - mispredict with alloc_req: alloc is dropped (alloc_ok=0).
  - mispredict with resolve_ok on a different slot: both apply, and the resolve clear is idempotent with the squash.
  - resolve_ok and mispredict on the same tag: mispredict wins.
- n_valid is updated every cycle: +1 on alloc, minus the number of slots cleared.

Decomposition:
- Add to package checkpoint_types: ckpt_entry_t (struct of the existing rat/freelist/prf_valid/rob_ptrs/rob_tag snapshot types plus the rob_tag key), and CKPT_IDX_W = $clog2(N_CKPT).
- Defaults come from ooop_types.
- One sub-module, ckpt_age_matrix: holds older[][], takes alloc index and invalidate mask, and outputs the younger-than-k mask.

Test Plan:
- Reset then 4 allocs (tags 1,2,3,4) -> alloc_ok=1 each, slots 0..3, n_valid=4, ckpt_full=1; a 5th alloc -> alloc_ok=0.
- Full table, resolve_ok tag 2 -> n_valid=3 next cycle; alloc tag 5 -> lands in slot 1 and is youngest.
- Tags 1,2,3 allocated, mispredict tag 2 -> next cycle restore_valid=1 with slot 1 data, slots for 2 and 3 cleared, n_valid=1.
- Alloc tag 7 with freelist=0; later commit_free preg 9 and wb preg 12; mispredict 7 -> restore_freelist[9]=1, restore_prf_valid[12]=1.
- mispredict tag 6 (absent) -> restore_miss=1, restore_valid=0, n_valid unchanged.
- Same-cycle alloc+mispredict -> alloc_ok=0; assert rst_n low mid-sequence -> all outputs 0 immediately.
